// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the MAR/MDR memory-access unit.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR_SU = 3'd2,
    WR    = 3'd3,
    WR_HD = 3'd4,
    DONE  = 3'd5
  } mem_state_t;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter for SRAM wait states; saturates at zero.
module wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: load wins over decrement, never wraps below zero
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access unit: Req/Ack handshake to an asynchronous SRAM with
// programmable wait states and byte-lane enables. Strobes are registered from next state.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [DATA_W-1:0]              Bus_in,
  input  logic                           LD_MAR,
  input  logic                           LD_MDR,
  input  logic                           Req,
  input  logic                           Wr,
  input  logic [lane_count(DATA_W)-1:0]  BE,
  output logic                           Busy,
  output logic                           Ack,
  output logic [ADDR_W-1:0]              MAR_out,
  output logic [DATA_W-1:0]              MDR_out,
  output logic [ADDR_W-1:0]              ADDR,
  inout  wire  [DATA_W-1:0]              Mem_Bus,
  output logic                           CE_n,
  output logic                           OE_n,
  output logic                           WE_n,
  output logic [lane_count(DATA_W)-1:0]  BE_n
);

  localparam int LANES = lane_count(DATA_W);
  localparam int CNT_W = $clog2(max_int(RD_WAIT, WR_WAIT) + 1);

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("mem_access_unit: DATA_W must be a multiple of 8");
  end
  if (WR_WAIT < 1) begin : g_bad_wr_wait
    $error("mem_access_unit: WR_WAIT must be at least 1");
  end

  mem_state_t        state_r, next_state_s;
  logic [LANES-1:0]  be_r, be_next_s;
  logic [ADDR_W-1:0] mar_r, bus_addr_s;
  logic [DATA_W-1:0] mdr_r, mdr_merge_s;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s, capture_s, active_s;
  logic [CNT_W-1:0]  cnt_load_val_s;
  logic              ce_n_r, oe_n_r, we_n_r, drive_r, busy_r, ack_r;
  logic [LANES-1:0]  be_n_r;

  if (ADDR_W > DATA_W) begin : g_addr_zext
    assign bus_addr_s = {{(ADDR_W-DATA_W){1'b0}}, Bus_in};
  end else begin : g_addr_trunc
    assign bus_addr_s = Bus_in[ADDR_W-1:0];
  end

  wait_counter #(.CNT_W(CNT_W)) u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Next-state decode and counter/capture control
  always_comb begin
    next_state_s   = state_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = {CNT_W{1'b0}};
    cnt_dec_s      = 1'b0;
    capture_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (Req) begin
          cnt_load_s     = 1'b1;
          cnt_load_val_s = Wr ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT);
          next_state_s   = Wr ? WR_SU : RD;
        end else begin
          next_state_s = IDLE;
        end
      end
      RD: begin
        cnt_dec_s = 1'b1;
        if (cnt_zero_s) begin
          capture_s    = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = RD;
        end
      end
      WR_SU: next_state_s = WR;
      WR: begin
        cnt_dec_s = 1'b1;
        if (cnt_zero_s) begin
          next_state_s = WR_HD;
        end else begin
          next_state_s = WR;
        end
      end
      WR_HD:   next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Lane merge for read capture: disabled lanes keep their previous MDR byte
  always_comb begin
    mdr_merge_s = mdr_r;
    for (int l = 0; l < LANES; l++) begin
      if (be_r[l]) begin
        mdr_merge_s[l*8 +: 8] = Mem_Bus[l*8 +: 8];
      end else begin
        mdr_merge_s[l*8 +: 8] = mdr_r[l*8 +: 8];
      end
    end
  end

  assign active_s  = (next_state_s == RD) || (next_state_s == WR_SU) ||
                     (next_state_s == WR) || (next_state_s == WR_HD);
  assign be_next_s = (state_r == IDLE) ? BE : be_r;

  // State, access attributes and MAR/MDR registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= IDLE;
      be_r    <= {LANES{1'b0}};
      mar_r   <= {ADDR_W{1'b0}};
      mdr_r   <= {DATA_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      be_r    <= be_next_s;
      if ((state_r == IDLE) && LD_MAR) begin
        mar_r <= bus_addr_s;
      end else begin
        mar_r <= mar_r;
      end
      if ((state_r == IDLE) && LD_MDR) begin
        mdr_r <= Bus_in;
      end else if (capture_s) begin
        mdr_r <= mdr_merge_s;
      end else begin
        mdr_r <= mdr_r;
      end
    end
  end

  // Registered SRAM strobes and handshake outputs, decoded from next state
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ce_n_r  <= 1'b1;
      oe_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      drive_r <= 1'b0;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      be_n_r  <= {LANES{1'b1}};
    end else begin
      ce_n_r  <= ~active_s;
      oe_n_r  <= ~(next_state_s == RD);
      we_n_r  <= ~(next_state_s == WR);
      drive_r <= active_s && (next_state_s != RD);
      busy_r  <= (next_state_s != IDLE);
      ack_r   <= (next_state_s == DONE);
      be_n_r  <= active_s ? ~be_next_s : {LANES{1'b1}};
    end
  end

  assign Mem_Bus = drive_r ? mdr_r : {DATA_W{1'bz}};

  assign Busy    = busy_r;
  assign Ack     = ack_r;
  assign MAR_out = mar_r;
  assign ADDR    = mar_r;
  assign MDR_out = mdr_r;
  assign CE_n    = ce_n_r;
  assign OE_n    = oe_n_r;
  assign WE_n    = we_n_r;
  assign BE_n    = be_n_r;

endmodule
